lock_tetromino: RTL and testbench
=================================

// Module: lock_tetromino
// PURPOSE
//  Writer side of the board RAM that the board renderer reads. On start, checks
//  the 4 cells of a tetromino at a given board anchor for bounds and occupancy.
//  If no cell collides and commit is set, it writes the piece colour into those
//  4 RAM words. Used for both move legality (check_only) and landing (commit).
// PARAMETERS
//  BOARD_W       10  board columns
//  BOARD_H       24  board rows; rows 0-3 are hidden, rows 4-23 are drawn
//  READ_LATENCY   1  RAM clocks from ram_addr to valid ram_Q (1..3)
// PORTS
//  clk         in   1  single system clock, all logic on posedge
//  reset       in   1  synchronous, active-high
//  start       in   1  request; sampled only in IDLE
//  commit      in   1  1 = write cells if clear; 0 = check only
//  coord_x     in   8  cell x offsets, 2 bits per cell, cell i at [2i+1:2i]
//  coord_y     in   8  cell y offsets, same packing (piece LUT format)
//  anchor_x    in   4  board column of piece origin
//  anchor_y    in   5  board row of piece origin
//  colour      in   6  piece colour; nonzero by contract, 0 = empty cell
//  ram_Q       in   6  RAM read data
//  ram_addr    out  8  RAM address = y*BOARD_W + x
//  ram_data    out  6  RAM write data (latched colour)
//  ram_wren    out  1  RAM write enable
//  busy        out  1  high from the cycle after start acceptance until done
//  done        out  1  one-cycle completion pulse
//  collision   out  1  result; valid with done, held until next accepted start
// BEHAVIOUR
//  Reset: state IDLE. ram_wren=0, busy=0, done=0, collision=0, ram_addr=0,
//   ram_data=0. Reset mid-operation aborts at once and issues no further writes.
//   A write already performed on an earlier cycle stays in RAM.
//   Reset beats a simultaneous start.
//  Accept: at edge t in IDLE with start=1, latch coord_x, coord_y, anchor_x,
//   anchor_y, colour and commit, and clear collision. start while busy is ignored.
//  Cell i (i=0..3): x = anchor_x + coord_x[i], y = anchor_y + coord_y[i].
//   Compute x and y at 5/6 bits so the sums do not wrap.
//   Out of bounds if x >= BOARD_W or y >= BOARD_H.
//  FSM: IDLE -> RD -> WT -> (next RD | WR | FIN) ; WR -> FIN ; FIN -> IDLE
//   RD  drive ram_addr for cell i. An out-of-bounds cell sets collision and goes
//       to FIN without reading.
//   WT  wait READ_LATENCY cycles with ram_addr held. In the last wait cycle,
//       compare ram_Q: nonzero sets collision and goes to FIN. Otherwise go to
//       RD for i+1; after cell 3, go to WR if commit, else FIN.
//   WR  4 cycles, cell 0..3 in order: ram_wren=1, ram_addr=cell addr,
//       ram_data=colour.
//   FIN done=1 for one cycle, busy=0; return to IDLE.
//  Timing: each cell check takes READ_LATENCY+1 cycles. Let L = 4*(READ_LATENCY+1).
//   Check-only pass: done in cycle t+L+1.
//   Commit pass: writes in cycles t+L+1 .. t+L+4, done in cycle t+L+5.
//   With READ_LATENCY=1: 9 and 13 cycles.
//   Collision at cell k: done in the cycle after cell k's RD (out of bounds) or
//   its final WT cycle (occupied).
//  ram_wren is asserted only in WR, never on a collision, never when commit=0.
//  Duplicate cell coordinates are not checked. Behaviour with colour=0 is
//   undefined.
//  busy and done are never high together. A start in the done cycle is ignored;
//   the next start is accepted from the following IDLE cycle.
// TESTING
//  1 Empty RAM, O piece (cx=8'h50, cy=8'h44), anchor (4,5), commit=1, colour=6'h30
//    -> wren in cycles t+9..t+12 at addrs 54,55,64,65; done at t+13; collision=0.
//  2 Same piece with addr 65 preloaded 6'h0C, commit=1 -> collision=1;
//    done at t+9; ram_wren never asserted; RAM unchanged.
//  3 I piece horizontal (cx=8'hE4, cy=0) at anchor_x=7 -> cell 3 has x=10,
//    out of bounds -> collision=1, done one cycle after cell 3's RD, no writes.
//  4 commit=0 on empty board at anchor (0,20) with cy all 3 -> y=23 is legal;
//    collision=0, done at t+9, no writes. Repeat at anchor_y=21 -> collision=1.
//  5 Assert reset at t+10 of a commit pass -> next cycle IDLE, busy=0, wren=0;
//    exactly one write (addr 54) in RAM. A new start is then accepted normally.
//  6 Pulse start while busy, and start together with reset -> both ignored; only
//    one done per accepted start. Rerun test 1 with READ_LATENCY=2 -> done at t+17.

Source files
------------

// File: rtl/lock_tetromino.sv
`default_nettype none
// ============================================================================
// Module   : lock_tetromino
// Purpose  : Board RAM writer. Checks a tetromino's 4 cells for bounds and
//            occupancy, then optionally writes the piece colour into them.
// Revision : 1.0  initial release
// ============================================================================
module lock_tetromino #(
    parameter int BOARD_W      = 10,
    parameter int BOARD_H      = 24,
    parameter int READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       commit,
    input  logic [7:0] coord_x,
    input  logic [7:0] coord_y,
    input  logic [3:0] anchor_x,
    input  logic [4:0] anchor_y,
    input  logic [5:0] colour,
    input  logic [5:0] ram_Q,
    output logic [7:0] ram_addr,
    output logic [5:0] ram_data,
    output logic       ram_wren,
    output logic       busy,
    output logic       done,
    output logic       collision
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_RD   = 3'd1;
    localparam logic [2:0] c_ST_WT   = 3'd2;
    localparam logic [2:0] c_ST_WR   = 3'd3;
    localparam logic [2:0] c_ST_FIN  = 3'd4;

    localparam logic [1:0] c_LAST_WAIT = 2'(READ_LATENCY - 1);
    localparam logic [1:0] c_LAST_CELL = 2'd3;

    logic [2:0] r_state;
    logic [2:0] w_next_state;

    logic [7:0] r_cx;
    logic [7:0] r_cy;
    logic [3:0] r_ax;
    logic [4:0] r_ay;
    logic [5:0] r_colour;
    logic       r_commit;
    logic [1:0] r_idx;
    logic [1:0] r_wait;
    logic       r_collision;

    logic [1:0] w_off_x;
    logic [1:0] w_off_y;
    logic [4:0] w_cell_x;
    logic [5:0] w_cell_y;
    logic       w_cell_oob;
    logic [7:0] w_cell_addr;
    logic       w_last_wait;
    logic       w_occupied;

    // Current cell coordinates, widened so anchor + offset cannot wrap
    always_comb begin
        w_off_x     = r_cx[{r_idx, 1'b0} +: 2];
        w_off_y     = r_cy[{r_idx, 1'b0} +: 2];
        w_cell_x    = {1'b0, r_ax} + {3'b000, w_off_x};
        w_cell_y    = {1'b0, r_ay} + {4'b0000, w_off_y};
        w_cell_oob  = (w_cell_x >= 5'(BOARD_W)) || (w_cell_y >= 6'(BOARD_H));
        w_cell_addr = 8'((10'(w_cell_y) * 10'(BOARD_W)) + 10'(w_cell_x));
    end

    assign w_last_wait = (r_wait == c_LAST_WAIT);
    assign w_occupied  = (ram_Q != 6'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_next_state = c_ST_RD;
                end
            end
            c_ST_RD: begin
                w_next_state = w_cell_oob ? c_ST_FIN : c_ST_WT;
            end
            c_ST_WT: begin
                if (w_last_wait) begin
                    if (w_occupied) begin
                        w_next_state = c_ST_FIN;
                    end else if (r_idx == c_LAST_CELL) begin
                        w_next_state = r_commit ? c_ST_WR : c_ST_FIN;
                    end else begin
                        w_next_state = c_ST_RD;
                    end
                end
            end
            c_ST_WR: begin
                if (r_idx == c_LAST_CELL) begin
                    w_next_state = c_ST_FIN;
                end
            end
            c_ST_FIN: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // Cell index wraps 3 -> 0 at the end of the check, ready for the write pass
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cx        <= 8'd0;
            r_cy        <= 8'd0;
            r_ax        <= 4'd0;
            r_ay        <= 5'd0;
            r_colour    <= 6'd0;
            r_commit    <= 1'b0;
            r_idx       <= 2'd0;
            r_wait      <= 2'd0;
            r_collision <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_cx        <= coord_x;
                        r_cy        <= coord_y;
                        r_ax        <= anchor_x;
                        r_ay        <= anchor_y;
                        r_colour    <= colour;
                        r_commit    <= commit;
                        r_idx       <= 2'd0;
                        r_wait      <= 2'd0;
                        r_collision <= 1'b0;
                    end
                end
                c_ST_RD: begin
                    r_wait <= 2'd0;
                    if (w_cell_oob) begin
                        r_collision <= 1'b1;
                    end
                end
                c_ST_WT: begin
                    if (w_last_wait) begin
                        if (w_occupied) begin
                            r_collision <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 2'd1;
                        end
                    end else begin
                        r_wait <= r_wait + 2'd1;
                    end
                end
                c_ST_WR: begin
                    r_idx <= r_idx + 2'd1;
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    // Write enable is gated by reset so an abort suppresses the in-flight write
    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        ram_wren = 1'b0;
        ram_addr = 8'd0;
        case (r_state)
            c_ST_RD, c_ST_WT: begin
                busy     = 1'b1;
                ram_addr = w_cell_addr;
            end
            c_ST_WR: begin
                busy     = 1'b1;
                ram_wren = ~reset;
                ram_addr = w_cell_addr;
            end
            c_ST_FIN: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign ram_data  = r_colour;
    assign collision = r_collision;

endmodule
`default_nettype wire

// File: tb/tb_lock_tetromino.sv
`default_nettype none
// ============================================================================
// Module   : tb_lock_tetromino
// Purpose  : Self-checking bench for lock_tetromino with behavioural RAM and
//            a cell-by-cell reference model of timing, collision and writes.
// Revision : 1.0  initial release
// ============================================================================
module tb_lock_tetromino;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset  = 1'b1;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic       commit = 1'b0;
    logic [7:0] cx     = 8'd0;
    logic [7:0] cy     = 8'd0;
    logic [3:0] ax     = 4'd0;
    logic [4:0] ay     = 5'd0;
    logic [5:0] colour = 6'd0;

    logic [5:0] q1, q2, q2a;
    logic [7:0] addr1, addr2;
    logic [5:0] data1, data2;
    logic       wren1, wren2, busy1, busy2, done1, done2, coll1, coll2;

    lock_tetromino #(.BOARD_W(10), .BOARD_H(24), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .commit(commit),
        .coord_x(cx), .coord_y(cy), .anchor_x(ax), .anchor_y(ay),
        .colour(colour), .ram_Q(q1), .ram_addr(addr1), .ram_data(data1),
        .ram_wren(wren1), .busy(busy1), .done(done1), .collision(coll1)
    );

    lock_tetromino #(.BOARD_W(10), .BOARD_H(24), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start2), .commit(commit),
        .coord_x(cx), .coord_y(cy), .anchor_x(ax), .anchor_y(ay),
        .colour(colour), .ram_Q(q2), .ram_addr(addr2), .ram_data(data2),
        .ram_wren(wren2), .busy(busy2), .done(done2), .collision(coll2)
    );

    // Behavioural board RAMs: one per instance, with matching read latency
    logic [5:0] mem1 [256];
    logic [5:0] mem2 [256];
    logic       ram_clr = 1'b0;
    logic       pl_en   = 1'b0;
    logic [7:0] pl_addr = 8'd0;
    logic [5:0] pl_val  = 6'd0;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int a = 0; a < 256; a++) begin
                mem1[a] <= 6'd0;
                mem2[a] <= 6'd0;
            end
        end else if (pl_en) begin
            mem1[pl_addr] <= pl_val;
            mem2[pl_addr] <= pl_val;
        end else begin
            if (wren1) mem1[addr1] <= data1;
            if (wren2) mem2[addr2] <= data2;
        end
        q1  <= mem1[addr1];
        q2a <= mem2[addr2];
        q2  <= q2a;
    end

    logic [5:0] exp_mem [256];
    int n_checks = 0;
    int n_fail   = 0;

    int m_coll, m_done, m_nwr;
    int m_addr [4];
    int got_done, got_coll, got_nwr;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic ram_clear();
        @(negedge clk); ram_clr = 1'b1;
        @(negedge clk); ram_clr = 1'b0;
        for (int a = 0; a < 256; a++) exp_mem[a] = 6'd0;
    endtask

    task automatic ram_preload(input logic [7:0] a, input logic [5:0] v);
        @(negedge clk); pl_en = 1'b1; pl_addr = a; pl_val = v;
        @(negedge clk); pl_en = 1'b0;
        exp_mem[a] = v;
    endtask

    function automatic int mem_diffs(input bit which);
        int n = 0;
        for (int a = 0; a < 256; a++)
            if ((which ? mem2[a] : mem1[a]) != exp_mem[a]) n++;
        return n;
    endfunction

    // Cells checked in order; each costs rl+1 cycles, then optional 4 writes
    task automatic model(input logic [7:0] mx, input logic [7:0] my,
                         input logic [3:0] max, input logic [4:0] may,
                         input logic mcommit, input int rl);
        int x, y, lat;
        lat = rl + 1;
        m_coll = 0; m_nwr = 0; m_done = 4 * lat + 1;
        for (int i = 0; i < 4; i++) begin
            x = int'(max) + int'(mx[2*i +: 2]);
            y = int'(may) + int'(my[2*i +: 2]);
            m_addr[i] = y * 10 + x;
            if (x >= 10 || y >= 24) begin
                m_coll = 1; m_done = i * lat + 2; break;
            end
            if (exp_mem[m_addr[i]] != 6'd0) begin
                m_coll = 1; m_done = (i + 1) * lat + 1; break;
            end
        end
        if (m_coll == 0 && mcommit) begin
            m_nwr = 4; m_done = m_done + 4;
        end
    endtask

    task automatic run_op(input bit which, input logic [7:0] tcx, input logic [7:0] tcy,
                          input logic [3:0] tax, input logic [4:0] tay,
                          input logic tcommit, input logic [5:0] tcol, input string name);
        int nd, nw, wr_err, busy_err;
        logic b, d, w, c;
        logic [7:0] a;
        logic [5:0] dat;
        model(tcx, tcy, tax, tay, tcommit, which ? 2 : 1);
        @(negedge clk);
        cx = tcx; cy = tcy; ax = tax; ay = tay; commit = tcommit; colour = tcol;
        if (which) start2 = 1'b1; else start1 = 1'b1;
        nd = 0; nw = 0; wr_err = 0; busy_err = 0; got_done = -1; got_coll = -1;
        for (int k = 1; k <= m_done + 3; k++) begin
            @(negedge clk);
            start1 = 1'b0; start2 = 1'b0;
            b = which ? busy2 : busy1;  d = which ? done2 : done1;
            w = which ? wren2 : wren1;  c = which ? coll2 : coll1;
            a = which ? addr2 : addr1;  dat = which ? data2 : data1;
            if (b && d) busy_err++;
            if (got_done < 0 && !d && !b) busy_err++;
            if (got_done >= 0 && b) busy_err++;
            if (d) begin
                nd++;
                if (got_done < 0) begin got_done = k; got_coll = int'(c); end
            end
            if (w) begin
                if (nw >= m_nwr || k != m_done - 4 + nw || int'(a) != m_addr[nw] || dat != tcol)
                    wr_err++;
                nw++;
            end
        end
        got_nwr = nw;
        check({name, " done_cycle"}, got_done, m_done);
        check({name, " collision"}, got_coll, m_coll);
        check({name, " collision_held"}, int'(which ? coll2 : coll1), m_coll);
        check({name, " done_count"}, nd, 1);
        check({name, " write_count"}, nw, m_nwr);
        check({name, " write_slots"}, wr_err, 0);
        check({name, " busy_shape"}, busy_err, 0);
        for (int j = 0; j < m_nwr; j++) exp_mem[m_addr[j]] = tcol;
        check({name, " ram_contents"}, mem_diffs(which), 0);
    endtask

    typedef struct {
        logic [7:0] cx, cy;
        logic [3:0] ax;
        logic [4:0] ay;
        logic       commit;
        logic [5:0] colour;
        int         pl_addr;
        logic [5:0] pl_val;
        int         exp_coll, exp_done, exp_nwr;
    } vec_t;

    vec_t vecs [9];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int nd, dcyc, late_busy, cnt;
        logic [7:0] rx, ry;
        logic [3:0] rax;
        logic [4:0] ray;

        vecs[0] = '{8'h50, 8'h44, 4'd4, 5'd5,  1'b1, 6'h30, -1,  6'h00, 0, 13, 4};
        vecs[1] = '{8'h50, 8'h44, 4'd4, 5'd5,  1'b1, 6'h30, 65,  6'h0C, 1, 9,  0};
        vecs[2] = '{8'hE4, 8'h00, 4'd7, 5'd10, 1'b1, 6'h15, -1,  6'h00, 1, 8,  0};
        vecs[3] = '{8'hE4, 8'hFF, 4'd0, 5'd20, 1'b0, 6'h21, -1,  6'h00, 0, 9,  0};
        vecs[4] = '{8'hE4, 8'hFF, 4'd0, 5'd21, 1'b0, 6'h21, -1,  6'h00, 1, 2,  0};
        vecs[5] = '{8'hFF, 8'h00, 4'd15, 5'd0, 1'b1, 6'h07, -1,  6'h00, 1, 2,  0};
        vecs[6] = '{8'h00, 8'hFF, 4'd0, 5'd31, 1'b1, 6'h07, -1,  6'h00, 1, 2,  0};
        vecs[7] = '{8'h00, 8'h00, 4'd9, 5'd23, 1'b1, 6'h2A, 239, 6'h01, 1, 3,  0};
        vecs[8] = '{8'h00, 8'h00, 4'd9, 5'd23, 1'b1, 6'h2A, -1,  6'h00, 0, 13, 4};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset busy", int'(busy1), 0);
        check("reset done", int'(done1), 0);
        check("reset wren", int'(wren1), 0);
        check("reset collision", int'(coll1), 0);
        check("reset addr", int'(addr1), 0);
        check("reset data", int'(data1), 0);
        reset = 1'b0;

        for (int v = 0; v < 9; v++) begin
            ram_clear();
            if (vecs[v].pl_addr >= 0) ram_preload(8'(vecs[v].pl_addr), vecs[v].pl_val);
            run_op(1'b0, vecs[v].cx, vecs[v].cy, vecs[v].ax, vecs[v].ay,
                   vecs[v].commit, vecs[v].colour, $sformatf("vec%0d", v));
            check($sformatf("vec%0d table_done", v), got_done, vecs[v].exp_done);
            check($sformatf("vec%0d table_coll", v), got_coll, vecs[v].exp_coll);
            check($sformatf("vec%0d table_writes", v), got_nwr, vecs[v].exp_nwr);
        end

        // Reset in the second write cycle of a commit pass
        ram_clear();
        @(negedge clk);
        cx = 8'h50; cy = 8'h44; ax = 4'd4; ay = 5'd5; commit = 1'b1; colour = 6'h30;
        start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1 check("abort wren_gated", int'(wren1), 0);
        @(negedge clk);
        check("abort busy", int'(busy1), 0);
        check("abort wren", int'(wren1), 0);
        check("abort done", int'(done1), 0);
        reset = 1'b0;
        @(negedge clk);
        exp_mem[54] = 6'h30;
        check("abort ram_one_write", mem_diffs(1'b0), 0);
        run_op(1'b0, 8'h50, 8'h44, 4'd4, 5'd5, 1'b1, 6'h11, "after_abort");
        check("after_abort coll", got_coll, 1);

        // start held while busy and pulsed in the done cycle
        ram_clear();
        @(negedge clk);
        cx = 8'h50; cy = 8'h44; ax = 4'd4; ay = 5'd5; commit = 1'b0; colour = 6'h30;
        start1 = 1'b1;
        nd = 0; dcyc = -1; late_busy = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done1) begin nd++; if (dcyc < 0) dcyc = k; end
            if (k > 9 && busy1) late_busy++;
            start1 = (k <= 3) || (k == 9);
        end
        start1 = 1'b0;
        check("busy_start done_count", nd, 1);
        check("busy_start done_cycle", dcyc, 9);
        check("busy_start late_busy", late_busy, 0);

        // start coincident with reset
        @(negedge clk); reset = 1'b1; start1 = 1'b1;
        @(negedge clk); reset = 1'b0; start1 = 1'b0;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (busy1 || done1) cnt++;
        end
        check("reset_start ignored", cnt, 0);

        // Two-cycle read latency instance
        ram_clear();
        run_op(1'b1, 8'h50, 8'h44, 4'd4, 5'd5, 1'b1, 6'h30, "rl2");
        check("rl2 table_done", got_done, 17);
        ram_clear();
        ram_preload(8'd64, 6'h05);
        run_op(1'b1, 8'h50, 8'h44, 4'd4, 5'd5, 1'b1, 6'h30, "rl2_occ");

        // Randomised operations against the reference model
        for (int n = 0; n < 40; n++) begin
            if (n % 8 == 0) begin
                ram_clear();
                for (int p = 0; p < 3; p++)
                    ram_preload(8'($urandom_range(0, 239)), 6'($urandom_range(1, 63)));
            end
            rx  = 8'($urandom);
            ry  = 8'($urandom);
            rax = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 8));
            ray = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 20));
            run_op(1'b0, rx, ry, rax, ray, 1'($urandom_range(0, 1)),
                   6'($urandom_range(1, 63)), $sformatf("rand%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
